// File: rtl/cb_douta_router.sv
// Routes one L-lane cache-bank read word to the A, B, M or TB-write-data consumer, applying a lane permutation on the way.
// Latency: 1 cycle, and every output is registered. Behind SEQ_DLY sits a free-running delay line that supplies the TB scatter step.
// Backpressure: none. A word is accepted on every cycle that CB_douta_vld is high, and outputs that are not addressed reload to 0.
//
// Ports:
//   clk, sys_rst_n          clock and asynchronous active-low reset
//   CB_douta_sel            [5:3] destination (IDLE/A/B/M/TBa/NL), [2:0] direction (IDLE/POS/NEG/NEW/ROT/NROT)
//   CB_douta_vld, CB_douta  input word valid and data (lane k = bits [k*RSA_DW +: RSA_DW])
//   l_k, rot, seq_cnt_out   landmark index, rotate amount and sequencer step, all sampled together with the word
//   sel_err_clr             clears the sticky illegal-select flag
//   {A,B,M,TB_dina}_CB_douta and {A,B,M,TB}_vld   routed data and its valid
//   sel_err                 sticky flag, set by an illegal dest/dir combination on a valid word
// Optional build macro CB_DOUTA_NL_CAPTURE_EN adds the xk/yk/xita/lkx/lky capture registers and makes dest code 111 legal.
module cb_douta_router #(
    parameter int L               = 4,
    parameter int X               = 4,
    parameter int Y               = 4,
    parameter int RSA_DW          = 32,
    parameter int SEQ_CNT_DW      = 5,
    parameter int SEQ_DLY         = 2,
    parameter int LK_W            = 4,
    parameter int CB_DOUTA_SEL_DW = 6
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
    input  logic                       CB_douta_vld,
    input  logic [L*RSA_DW-1:0]        CB_douta,
    input  logic [LK_W-1:0]            l_k,
    input  logic [$clog2(L)-1:0]       rot,
    input  logic [SEQ_CNT_DW-1:0]      seq_cnt_out,
    input  logic                       sel_err_clr,
    output logic [X*RSA_DW-1:0]        A_CB_douta,
    output logic                       A_vld,
    output logic [Y*RSA_DW-1:0]        B_CB_douta,
    output logic                       B_vld,
    output logic [X*RSA_DW-1:0]        M_CB_douta,
    output logic                       M_vld,
    output logic [X*RSA_DW-1:0]        TB_dina_CB_douta,
    output logic                       TB_vld,
    output logic                       sel_err
`ifdef CB_DOUTA_NL_CAPTURE_EN
    ,
    output logic [RSA_DW-1:0]          xk,
    output logic [RSA_DW-1:0]          yk,
    output logic [RSA_DW-1:0]          xita,
    output logic [RSA_DW-1:0]          lkx,
    output logic [RSA_DW-1:0]          lky
`endif
);

    localparam logic [2:0] DST_IDLE = 3'd0;
    localparam logic [2:0] DST_A    = 3'd1;
    localparam logic [2:0] DST_B    = 3'd2;
    localparam logic [2:0] DST_M    = 3'd3;
    localparam logic [2:0] DST_TB   = 3'd4;
`ifdef CB_DOUTA_NL_CAPTURE_EN
    localparam logic [2:0] DST_NL   = 3'd7;
`endif

    localparam logic [2:0] DIR_IDLE = 3'd0;
    localparam logic [2:0] DIR_POS  = 3'd1;
    localparam logic [2:0] DIR_NEG  = 3'd2;
    localparam logic [2:0] DIR_NEW  = 3'd3;
    localparam logic [2:0] DIR_ROT  = 3'd4;
    localparam logic [2:0] DIR_NROT = 3'd5;

    // ------------------------------------------------------------------
    // Select decode
    // ------------------------------------------------------------------
    logic [2:0] w_dest;
    logic [2:0] w_dir;
    logic       w_is_nl;
    logic       w_dest_ok;
    logic       w_dir_ok;
    logic       w_tb_bad;
    logic       w_err;
    logic       w_go;
    logic       w_a_ld;
    logic       w_b_ld;
    logic       w_m_ld;
    logic       w_tb_ld;

    assign w_dest = CB_douta_sel[5:3];
    assign w_dir  = CB_douta_sel[2:0];

`ifdef CB_DOUTA_NL_CAPTURE_EN
    assign w_is_nl = (w_dest == DST_NL);
`else
    assign w_is_nl = 1'b0;
`endif

    assign w_dest_ok = (w_dest <= DST_TB) | w_is_nl;
    assign w_dir_ok  = (w_dir <= DIR_NROT);
    // The TB port only understands the landmark-pair scatter.
    assign w_tb_bad  = (w_dest == DST_TB) & (w_dir != DIR_IDLE) & (w_dir != DIR_NEW);
    // NL capture ignores the direction field, so an illegal direction is not an error there.
    assign w_err     = CB_douta_vld & (~w_dest_ok | (~w_is_nl & ~w_dir_ok) | w_tb_bad);
    assign w_go      = CB_douta_vld & ~w_err & ~w_is_nl & (w_dir != DIR_IDLE);

    assign w_a_ld  = w_go & (w_dest == DST_A);
    assign w_b_ld  = w_go & (w_dest == DST_B);
    assign w_m_ld  = w_go & (w_dest == DST_M);
    assign w_tb_ld = w_go & (w_dest == DST_TB);

    // ------------------------------------------------------------------
    // Input lanes and landmark pair
    // ------------------------------------------------------------------
    logic [RSA_DW-1:0] w_in [L];
    logic [RSA_DW-1:0] w_lo;
    logic [RSA_DW-1:0] w_hi;
    int                w_pb;

    always_comb begin
        for (int k = 0; k < L; k++) begin
            w_in[k] = CB_douta[k*RSA_DW +: RSA_DW];
        end
    end

    // The sequencer has already bumped l_k by the time NEW reaches us,
    // so the pair base is taken from the following landmark.
    always_comb begin
        w_pb = 2 * ((int'(l_k) + 1) % (L / 2));
    end

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        for (int j = 0; j < L; j++) begin
            if (j == w_pb)     w_lo = w_in[j];
            if (j == w_pb + 1) w_hi = w_in[j];
        end
    end

    // ------------------------------------------------------------------
    // Seq delay line, which shifts on every cycle regardless of word valid
    // ------------------------------------------------------------------
    logic [SEQ_CNT_DW-1:0] r_seq_dly [SEQ_DLY];

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < SEQ_DLY; k++) begin
                r_seq_dly[k] <= '0;
            end
        end else begin
            r_seq_dly[0] <= seq_cnt_out;
            for (int k = 1; k < SEQ_DLY; k++) begin
                r_seq_dly[k] <= r_seq_dly[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane permutation for A/B/M
    // ------------------------------------------------------------------
    logic [RSA_DW-1:0] w_map [L];

    always_comb begin
        int rix;
        for (int i = 0; i < L; i++) begin
            w_map[i] = '0;
            rix      = (i + int'(rot)) % L;
            case (w_dir)
                DIR_POS: w_map[i] = w_in[i];
                DIR_NEG: w_map[i] = w_in[L-1-i];
                DIR_NEW: begin
                    if (i == 0)      w_map[i] = w_lo;
                    else if (i == 1) w_map[i] = w_hi;
                end
                DIR_ROT: begin
                    for (int j = 0; j < L; j++) begin
                        if (j == rix) w_map[i] = w_in[j];
                    end
                end
                DIR_NROT: begin
                    for (int j = 0; j < L; j++) begin
                        if (j == L - 1 - rix) w_map[i] = w_in[j];
                    end
                end
                default: w_map[i] = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TB diagonal scatter. At step s the pair sits on lanes s-2 (hi) and s-1 (lo).
    // At s=0 only hi is placed, and it wraps to the top lane.
    // ------------------------------------------------------------------
    logic [RSA_DW-1:0] w_tb [L];

    always_comb begin
        int s;
        s = int'(r_seq_dly[SEQ_DLY-1]);
        for (int i = 0; i < L; i++) begin
            w_tb[i] = '0;
            if (s == 0 && i == L - 1)               w_tb[i] = w_hi;
            if (s >= 1 && s <= L && i == s - 1)     w_tb[i] = w_lo;
            if (s >= 2 && s <= L && i == s - 2)     w_tb[i] = w_hi;
        end
    end

    // ------------------------------------------------------------------
    // Next output words. Destinations that are not addressed load 0.
    // ------------------------------------------------------------------
    logic [X*RSA_DW-1:0] w_a_nxt;
    logic [Y*RSA_DW-1:0] w_b_nxt;
    logic [X*RSA_DW-1:0] w_m_nxt;
    logic [X*RSA_DW-1:0] w_tb_nxt;

    always_comb begin
        w_a_nxt  = '0;
        w_b_nxt  = '0;
        w_m_nxt  = '0;
        w_tb_nxt = '0;
        for (int i = 0; i < X; i++) begin
            if (w_a_ld)  w_a_nxt[i*RSA_DW +: RSA_DW]  = w_map[i];
            if (w_m_ld)  w_m_nxt[i*RSA_DW +: RSA_DW]  = w_map[i];
            if (w_tb_ld) w_tb_nxt[i*RSA_DW +: RSA_DW] = w_tb[i];
        end
        for (int i = 0; i < Y; i++) begin
            if (w_b_ld)  w_b_nxt[i*RSA_DW +: RSA_DW]  = w_map[i];
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [X*RSA_DW-1:0] r_a;
    logic [Y*RSA_DW-1:0] r_b;
    logic [X*RSA_DW-1:0] r_m;
    logic [X*RSA_DW-1:0] r_tb;
    logic                r_a_vld;
    logic                r_b_vld;
    logic                r_m_vld;
    logic                r_tb_vld;
    logic                r_sel_err;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_tb     <= '0;
            r_a_vld  <= 1'b0;
            r_b_vld  <= 1'b0;
            r_m_vld  <= 1'b0;
            r_tb_vld <= 1'b0;
        end else begin
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_m      <= w_m_nxt;
            r_tb     <= w_tb_nxt;
            r_a_vld  <= w_a_ld;
            r_b_vld  <= w_b_ld;
            r_m_vld  <= w_m_ld;
            r_tb_vld <= w_tb_ld;
        end
    end

    // A new error takes priority over a clear that lands in the same cycle.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_err) begin
            r_sel_err <= 1'b1;
        end else if (sel_err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign A_CB_douta       = r_a;
    assign B_CB_douta       = r_b;
    assign M_CB_douta       = r_m;
    assign TB_dina_CB_douta = r_tb;
    assign A_vld            = r_a_vld;
    assign B_vld            = r_b_vld;
    assign M_vld            = r_m_vld;
    assign TB_vld           = r_tb_vld;
    assign sel_err          = r_sel_err;

`ifdef CB_DOUTA_NL_CAPTURE_EN
    // ------------------------------------------------------------------
    // NL capture. The registers are keyed on the undelayed sequencer step and hold between captures.
    // ------------------------------------------------------------------
    logic [RSA_DW-1:0] r_xk;
    logic [RSA_DW-1:0] r_yk;
    logic [RSA_DW-1:0] r_xita;
    logic [RSA_DW-1:0] r_lkx;
    logic [RSA_DW-1:0] r_lky;
    int                w_seq;

    always_comb begin
        w_seq = int'(seq_cnt_out);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xk   <= '0;
            r_yk   <= '0;
            r_xita <= '0;
            r_lkx  <= '0;
            r_lky  <= '0;
        end else if (CB_douta_vld && w_is_nl) begin
            if (w_seq == 7)        r_xk   <= w_in[0];
            if (w_seq == 8)        r_yk   <= w_in[1];
            if (w_seq == 9)        r_xita <= w_in[2];
            if (w_seq == 8 + w_pb) r_lkx  <= w_lo;
            if (w_seq == 9 + w_pb) r_lky  <= w_hi;
        end
    end

    assign xk   = r_xk;
    assign yk   = r_yk;
    assign xita = r_xita;
    assign lkx  = r_lkx;
    assign lky  = r_lky;
`endif

endmodule

// File: tb/tb_cb_douta_router.sv
// Testbench for cb_douta_router: directed steps followed by a randomized run, checked against a behavioural model.
// Latency: the checks expect each word's outputs one clock edge after the word is driven.
// Backpressure: none to model. The bench drives one word per cycle.
module tb_cb_douta_router;

    localparam int L          = 4;
    localparam int X          = 4;
    localparam int Y          = 4;
    localparam int RSA_DW     = 32;
    localparam int SEQ_CNT_DW = 5;
    localparam int SEQ_DLY    = 2;
    localparam int LK_W       = 4;
    localparam int SDW        = 6;
    localparam int W          = L * RSA_DW;

    logic                   clk = 1'b0;
    logic                   sys_rst_n;
    logic [SDW-1:0]         d_sel;
    logic                   d_vld;
    logic [W-1:0]           d_word;
    logic [LK_W-1:0]        d_lk;
    logic [$clog2(L)-1:0]   d_rot;
    logic [SEQ_CNT_DW-1:0]  d_seq;
    logic                   d_clr;

    logic [X*RSA_DW-1:0]    A_CB_douta;
    logic [Y*RSA_DW-1:0]    B_CB_douta;
    logic [X*RSA_DW-1:0]    M_CB_douta;
    logic [X*RSA_DW-1:0]    TB_dina_CB_douta;
    logic                   A_vld;
    logic                   B_vld;
    logic                   M_vld;
    logic                   TB_vld;
    logic                   sel_err;

    int tests = 0;
    int fails = 0;

    // Expected values produced by the reference model
    logic [X*RSA_DW-1:0] e_a;
    logic [Y*RSA_DW-1:0] e_b;
    logic [X*RSA_DW-1:0] e_m;
    logic [X*RSA_DW-1:0] e_tb;
    logic                e_av;
    logic                e_bv;
    logic                e_mv;
    logic                e_tv;
    logic                e_err;
    int                  q_seq[$];

    cb_douta_router #(
        .L(L), .X(X), .Y(Y), .RSA_DW(RSA_DW), .SEQ_CNT_DW(SEQ_CNT_DW),
        .SEQ_DLY(SEQ_DLY), .LK_W(LK_W), .CB_DOUTA_SEL_DW(SDW)
    ) dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .CB_douta_sel     (d_sel),
        .CB_douta_vld     (d_vld),
        .CB_douta         (d_word),
        .l_k              (d_lk),
        .rot              (d_rot),
        .seq_cnt_out      (d_seq),
        .sel_err_clr      (d_clr),
        .A_CB_douta       (A_CB_douta),
        .A_vld            (A_vld),
        .B_CB_douta       (B_CB_douta),
        .B_vld            (B_vld),
        .M_CB_douta       (M_CB_douta),
        .M_vld            (M_vld),
        .TB_dina_CB_douta (TB_dina_CB_douta),
        .TB_vld           (TB_vld),
        .sel_err          (sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A"},    W'(A_CB_douta),       W'(e_a));
        chk({tag, ".B"},    W'(B_CB_douta),       W'(e_b));
        chk({tag, ".M"},    W'(M_CB_douta),       W'(e_m));
        chk({tag, ".TB"},   W'(TB_dina_CB_douta), W'(e_tb));
        chk({tag, ".Av"},   W'(A_vld),            W'(e_av));
        chk({tag, ".Bv"},   W'(B_vld),            W'(e_bv));
        chk({tag, ".Mv"},   W'(M_vld),            W'(e_mv));
        chk({tag, ".TBv"},  W'(TB_vld),           W'(e_tv));
        chk({tag, ".err"},  W'(sel_err),          W'(e_err));
    endtask

    task automatic model_reset();
        e_a = '0; e_b = '0; e_m = '0; e_tb = '0;
        e_av = 1'b0; e_bv = 1'b0; e_mv = 1'b0; e_tv = 1'b0; e_err = 1'b0;
        q_seq = {};
        repeat (SEQ_DLY) q_seq.push_back(0);
    endtask

    // Reference model: computes, from the routing rules, the outputs expected after the next edge.
    task automatic model(input logic [SDW-1:0] sel, input logic v, input logic [W-1:0] w,
                         input logic [LK_W-1:0] lk, input logic [$clog2(L)-1:0] r,
                         input logic [SEQ_CNT_DW-1:0] sq, input logic clr);
        logic [RSA_DW-1:0] inl  [L];
        logic [RSA_DW-1:0] outl [L];
        int  dest, dir, s, pb, rr;
        bit  illegal, active;
        for (int k = 0; k < L; k++) begin
            inl[k]  = w[k*RSA_DW +: RSA_DW];
            outl[k] = '0;
        end
        dest = int'(sel[5:3]);
        dir  = int'(sel[2:0]);
        rr   = int'(r);
        pb   = 2 * ((int'(lk) + 1) % (L / 2));
        s    = q_seq.pop_front();
        q_seq.push_back(int'(sq));
        illegal = (dest >= 5) || (dir >= 6) || (dest == 4 && dir != 0 && dir != 3);
        active  = v && !illegal && dir != 0 && dest != 0;
        if (active) begin
            if (dest == 4) begin
                if (s == 0) outl[L-1] = inl[pb+1];
                else if (s <= L) begin
                    outl[s-1] = inl[pb];
                    if (s >= 2) outl[s-2] = inl[pb+1];
                end
            end else begin
                for (int i = 0; i < L; i++) begin
                    case (dir)
                        1: outl[i] = inl[i];
                        2: outl[i] = inl[L-1-i];
                        3: outl[i] = (i == 0) ? inl[pb] : (i == 1) ? inl[pb+1] : '0;
                        4: outl[i] = inl[(i + rr) % L];
                        5: outl[i] = inl[L-1-((i + rr) % L)];
                        default: outl[i] = '0;
                    endcase
                end
            end
        end
        e_a = '0; e_b = '0; e_m = '0; e_tb = '0;
        for (int i = 0; i < X; i++) begin
            if (active && dest == 1) e_a[i*RSA_DW +: RSA_DW]  = outl[i];
            if (active && dest == 3) e_m[i*RSA_DW +: RSA_DW]  = outl[i];
            if (active && dest == 4) e_tb[i*RSA_DW +: RSA_DW] = outl[i];
        end
        for (int i = 0; i < Y; i++) begin
            if (active && dest == 2) e_b[i*RSA_DW +: RSA_DW]  = outl[i];
        end
        e_av  = active && dest == 1;
        e_bv  = active && dest == 2;
        e_mv  = active && dest == 3;
        e_tv  = active && dest == 4;
        e_err = (v && illegal) || (e_err && !clr);
    endtask

    // One word: drive, update model, clock, check everything 1 time unit after the edge.
    task automatic step(input string tag, input logic [SDW-1:0] sel, input logic v,
                        input logic [W-1:0] w, input logic [LK_W-1:0] lk,
                        input logic [$clog2(L)-1:0] r, input logic [SEQ_CNT_DW-1:0] sq,
                        input logic clr);
        d_sel = sel; d_vld = v; d_word = w; d_lk = lk; d_rot = r; d_seq = sq; d_clr = clr;
        model(sel, v, w, lk, r, sq, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] rw;
        logic [2:0]   rdest, rdir;
        word = {32'h44, 32'h33, 32'h22, 32'h11};

        // Reset
        sys_rst_n = 1'b0;
        d_sel = '0; d_vld = 1'b0; d_word = '0; d_lk = '0; d_rot = '0; d_seq = '0; d_clr = 1'b0;
        model_reset();
        #22;
        check_all("reset");
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A / POS
        step("a_pos", 6'o11, 1'b1, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("a_pos_const", W'(A_CB_douta), {32'h44, 32'h33, 32'h22, 32'h11});

        // B / NEG, then an invalid word clears B
        step("b_neg", 6'o22, 1'b1, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("b_neg_const", W'(B_CB_douta), {32'h11, 32'h22, 32'h33, 32'h44});
        step("b_novld", 6'o22, 1'b0, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("b_novld_const", W'(B_CB_douta), '0);

        // M / ROT and NROT with rot=1
        step("m_rot", 6'o34, 1'b1, word, 4'd0, 2'd1, 5'd0, 1'b0);
        chk("m_rot_const", W'(M_CB_douta), {32'h11, 32'h44, 32'h33, 32'h22});
        step("m_nrot", 6'o35, 1'b1, word, 4'd0, 2'd1, 5'd0, 1'b0);
        chk("m_nrot_const", W'(M_CB_douta), {32'h44, 32'h11, 32'h22, 32'h33});

        // TB scatter: seq=3 presented two cycles before the word
        step("tb_pre0", 6'o00, 1'b0, word, 4'd0, 2'd0, 5'd3, 1'b0);
        step("tb_pre1", 6'o00, 1'b0, word, 4'd0, 2'd0, 5'd0, 1'b0);
        step("tb_s3", 6'o43, 1'b1, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("tb_s3_const", W'(TB_dina_CB_douta), {32'h0, 32'h33, 32'h44, 32'h0});
        // Sweep: the word of iteration k sees s = k-2
        for (int k = 0; k < 8; k++) begin
            step("tb_sweep", 6'o43, 1'b1, word, 4'd0, 2'd0, 5'(k), 1'b0);
            if (k == 2) chk("tb_s0_const", W'(TB_dina_CB_douta), {32'h44, 32'h0, 32'h0, 32'h0});
            if (k == 3) chk("tb_s1_const", W'(TB_dina_CB_douta), {32'h0, 32'h0, 32'h0, 32'h33});
            if (k == 7) begin
                chk("tb_s5_const", W'(TB_dina_CB_douta), '0);
                chk("tb_s5_vld", W'(TB_vld), W'(1'b1));
            end
        end

        // Illegal destination, then sticky hold, clear, and set-beats-clear
        step("ill_dest", 6'o61, 1'b1, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("ill_err_const", W'(sel_err), W'(1'b1));
        for (int k = 0; k < 10; k++) step("err_hold", 6'o00, 1'b0, word, 4'd0, 2'd0, 5'd0, 1'b0);
        chk("err_hold_const", W'(sel_err), W'(1'b1));
        step("err_clr", 6'o00, 1'b0, word, 4'd0, 2'd0, 5'd0, 1'b1);
        chk("err_clr_const", W'(sel_err), W'(1'b0));
        step("err_setclr", 6'o46, 1'b1, word, 4'd0, 2'd0, 5'd0, 1'b1);
        chk("err_setclr_const", W'(sel_err), W'(1'b1));

        // Asynchronous reset mid-stream
        step("pre_rst", 6'o11, 1'b1, word, 4'd0, 2'd0, 5'd7, 1'b0);
        step("pre_rst2", 6'o11, 1'b1, word, 4'd0, 2'd0, 5'd6, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        d_sel = '0; d_vld = 1'b0; d_seq = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst0", 6'o43, 1'b1, word, 4'd0, 2'd0, 5'd7, 1'b0);
        chk("post_rst0_const", W'(TB_dina_CB_douta), {32'h44, 32'h0, 32'h0, 32'h0});
        step("post_rst1", 6'o43, 1'b1, word, 4'd0, 2'd0, 5'd7, 1'b0);
        chk("post_rst1_const", W'(TB_dina_CB_douta), {32'h44, 32'h0, 32'h0, 32'h0});

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < L; k++) rw[k*RSA_DW +: RSA_DW] = $urandom;
            rdest = 3'($urandom_range(0, 7));
            rdir  = (rdest == 3'd4 && $urandom_range(0, 3) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
            step("rand", {rdest, rdir}, ($urandom_range(0, 4) != 0), rw,
                 LK_W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 SEQ_CNT_DW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cb_douta_router.md
Name: cb_douta_router

Overview:
- Parametrised successor to the cache-bank port-A output mapper.
- Takes one L-lane CB read word and routes it to exactly one consumer (RSA A side, B side, M side, or TB write-data), one cycle after the read.
- Lane permutations per consumer: identity, reverse, arbitrary rotate, reverse-rotate, and new-landmark pair extract.
- Also does a generalised seq-driven diagonal scatter for TB initialisation, with per-output valids and a sticky illegal-select flag.

Parameters:
- L, 4, CB lanes; even, >=4.
- X, 4, A/M/TB output lanes (<=L).
- Y, 4, B output lanes (<=L).
- RSA_DW, 32, lane data width.
- SEQ_CNT_DW, 5, seq counter width.
- SEQ_DLY, 2, pipeline delay applied to seq_cnt_out for TB scatter (1..4).
- LK_W, 4, landmark index width.
- CB_DOUTA_SEL_DW, 6, select width.

Ports:
- clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- CB_douta_sel  in  CB_DOUTA_SEL_DW  [5:3] destination, [2:0] direction.
- CB_douta_vld  in  1  CB_douta valid this cycle.
- CB_douta  in  L*RSA_DW  CB read word; lane k = bits [k*RSA_DW +: RSA_DW].
- l_k  in  LK_W  current landmark index.
- rot  in  clog2(L)  rotate amount.
- seq_cnt_out  in  SEQ_CNT_DW  sequencer step.
- sel_err_clr  in  1  clears sel_err.
- A_CB_douta / A_vld  out  X*RSA_DW / 1.
- B_CB_douta / B_vld  out  Y*RSA_DW / 1.
- M_CB_douta / M_vld  out  X*RSA_DW / 1.
- TB_dina_CB_douta / TB_vld  out  X*RSA_DW / 1.
- sel_err  out  1  sticky illegal-select flag.

Behaviour:
- Reset: sys_rst_n low asynchronously clears all data outputs, all valids, sel_err, and the seq delay line to 0.
- Destination codes: 000 IDLE, 001 A, 010 B, 011 M, 100 TBa, 111 NL (optional feature only). 101/110 are illegal.
- Direction codes: 000 IDLE, 001 POS, 010 NEG, 011 NEW, 100 ROT, 101 NROT. 110/111 are illegal.
- Mapping, output lane i from input:
  - POS: in[i].
  - NEG: in[L-1-i].
  - ROT: in[(i+rot) mod L].
  - NROT: in[L-1-((i+rot) mod L)].
  - NEW: lane0 = in[pb], lane1 = in[pb+1], other lanes 0.
  - pb = 2*((l_k+1) mod (L/2)); the +1 accounts for the sequencer incrementing l_k on entering NEW.
- Output width: lanes i >= L are 0; lanes beyond the output width are dropped.
- Latency is 1 cycle; all outputs are registered.
- Only the addressed destination output is loaded. Every other destination output is loaded with 0 each cycle; there is no hold.
- If CB_douta_vld=0, dir=IDLE, or dest=IDLE: all data outputs 0 and all valids 0 next cycle.
- X_vld = registered (CB_douta_vld & dest match & legal non-IDLE dir).
- TBa accepts NEW only; any other non-IDLE dir with TBa is illegal.
- TB scatter: uses s = seq_cnt_out delayed SEQ_DLY cycles through an internal shift register that runs every cycle. With lo = in[pb], hi = in[pb+1]:
  - s=0: lane L-1 = hi.
  - 1<=s<=L: lane s-2 = hi (when s>=2), lane s-1 = lo.
  - s>L: all lanes 0, TB_vld still 1.
  - All unnamed lanes are 0.
- Illegal dest or dir with CB_douta_vld=1: all outputs 0, no valid, sel_err set next cycle.
- sel_err holds until sel_err_clr. If a set and a clear land in the same cycle, set wins.
- l_k, rot and sel are sampled in the same cycle as CB_douta; the router keeps no state across words other than the seq delay line and sel_err.
- Asserting reset mid-stream discards in-flight data; the first valid output after reset release appears 1 cycle after the first valid input.

Optional Feature:
- Macro CB_DOUTA_NL_CAPTURE_EN.
- Defined:
  - Adds outputs xk, yk, xita, lkx, lky (each RSA_DW, reset 0).
  - Dest code 111 is legal; dir is ignored and no *_vld is asserted.
  - Capture is gated by CB_douta_vld and keyed on the undelayed seq_cnt_out:
    - xk <= in[0] at seq 7.
    - yk <= in[1] at seq 8.
    - xita <= in[2] at seq 9.
    - lkx <= in[pb] at seq 8+pb.
    - lky <= in[pb+1] at seq 9+pb.
  - Registers hold otherwise.
- Undefined: ports and registers are absent, and dest 111 is illegal (sets sel_err).

Test Plan (L=X=Y=4, lanes in0..3 = 0x11, 0x22, 0x33, 0x44):
- Dest A, POS, vld=1 -> next cycle A lanes0..3 = 11, 22, 33, 44; A_vld=1; B, M, TB = 0; other valids 0.
- Dest B, NEG -> B lanes = 44, 33, 22, 11. Then vld=0 on the next word -> B = 0, B_vld=0.
- Dest M, ROT, rot=1 -> M lanes = 22, 33, 44, 11. Dest M, NROT, rot=1 -> 33, 22, 11, 44.
- Dest TBa, NEW, l_k=0 (pb=2), seq_cnt_out=3 presented 2 cycles before the word -> TB lane1=0x44, lane2=0x33, lanes0/3=0. Sweep s=0..5 and check the diagonal, plus zeros at s=5.
- Dest 110 with vld=1 -> all outputs 0 and sel_err=1. sel_err holds 10 cycles, then clr -> 0. Set and clr in the same cycle -> 1.
- sys_rst_n pulsed low asynchronously mid-stream with outputs nonzero -> outputs, valids and sel_err 0 immediately. Delay line flushed: with TBa NEW held, the first TB words after release see s=0.
